// File: rtl/mode_sequencer_pkg.sv
`default_nettype none
// =============================================================================
// mode_seq_pkg : state encodings and button indices for the watch sequencer
// Rev 1.0
// =============================================================================
package mode_seq_pkg;

   typedef enum logic [2:0] {
      ST_WATCH   = 3'd0,
      ST_SET_NOW = 3'd1,
      ST_SET_ARM = 3'd2,
      ST_RING    = 3'd3,
      ST_SNOOZE  = 3'd4
   } state_t;

   localparam int c_NUM_BTN   = 5;
   localparam int c_BTN_DOWN  = 0;
   localparam int c_BTN_UP    = 1;
   localparam int c_BTN_SHIFT = 2;
   localparam int c_BTN_CHMOD = 3;
   localparam int c_BTN_OK    = 4;

endpackage
`default_nettype wire

// File: rtl/mode_sequencer_if.sv
`default_nettype none
// =============================================================================
// mode_sequencer_if : front-panel buttons, time strobes and mode/edit outputs
// Rev 1.0
// =============================================================================
interface mode_sequencer_if;
   logic       chmod;
   logic       OK;
   logic       shift;
   logic       up;
   logic       down;
   logic       sec_tick;
   logic       alarm_match;
   logic [2:0] STATE;
   logic [2:0] cursor;
   logic       inc_pulse;
   logic       dec_pulse;
   logic       commit_now;
   logic       commit_arm;
   logic       cancel;
   logic       alarm_on;
   logic       ring_en;

   modport master (
      output chmod, OK, shift, up, down, sec_tick, alarm_match,
      input  STATE, cursor, inc_pulse, dec_pulse, commit_now, commit_arm,
             cancel, alarm_on, ring_en
   );

   modport slave (
      input  chmod, OK, shift, up, down, sec_tick, alarm_match,
      output STATE, cursor, inc_pulse, dec_pulse, commit_now, commit_arm,
             cancel, alarm_on, ring_en
   );
endinterface
`default_nettype wire

// File: rtl/mode_sequencer_btn_pulse.sv
`default_nettype none
// =============================================================================
// btn_pulse : 2-flop sync, stable-level debounce, one-cycle rising-edge event
// Rev 1.0
// =============================================================================
module btn_pulse #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  wire logic CLK,
   input  wire logic RESETN,
   input  wire logic i_raw,
   output logic      o_pulse
);
   localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic               r_stable;
   logic               r_stable_d;
   logic               r_pulse;
   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_pulse    <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         // Any bounce back to the accepted level restarts the hold count.
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == c_CNT_LAST) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_stable_d <= r_stable;
         r_pulse    <= r_stable & ~r_stable_d;
      end
   end

   assign o_pulse = r_pulse;
endmodule
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// =============================================================================
// mode_sequencer : alarm-watch mode FSM (WATCH/SET_NOW/SET_ARM/RING/SNOOZE)
// Optional snooze feature enabled by defining MODE_SEQ_SNOOZE_EN.  Rev 1.0
// =============================================================================
module mode_sequencer
   import mode_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 16,
   parameter int RING_SEC     = 60,
   parameter int SNOOZE_SEC   = 300,
   parameter int NUM_FIELDS   = 6
) (
   input  wire logic        CLK,
   input  wire logic        RESETN,
   mode_sequencer_if.slave  bus
);
   localparam logic [6:0] c_RING_LAST   = 7'(RING_SEC - 1);
   localparam logic [8:0] c_SNOOZE_LAST = 9'(SNOOZE_SEC - 1);
   localparam logic [2:0] c_CURSOR_LAST = 3'(NUM_FIELDS - 1);

   logic [c_NUM_BTN-1:0] w_raw;
   logic [c_NUM_BTN-1:0] w_ev;

   assign w_raw[c_BTN_DOWN]  = bus.down;
   assign w_raw[c_BTN_UP]    = bus.up;
   assign w_raw[c_BTN_SHIFT] = bus.shift;
   assign w_raw[c_BTN_CHMOD] = bus.chmod;
   assign w_raw[c_BTN_OK]    = bus.OK;

   for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
      btn_pulse #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
         .CLK    (CLK),
         .RESETN (RESETN),
         .i_raw  (w_raw[gi]),
         .o_pulse(w_ev[gi])
      );
   end

   // Fixed priority: only the highest-ranked simultaneous event survives.
   logic w_win_ok, w_win_chmod, w_win_shift, w_win_up, w_win_down, w_any_ev;
   assign w_win_ok    = w_ev[c_BTN_OK];
   assign w_win_chmod = w_ev[c_BTN_CHMOD] & ~w_ev[c_BTN_OK];
   assign w_win_shift = w_ev[c_BTN_SHIFT] & ~w_ev[c_BTN_CHMOD] & ~w_ev[c_BTN_OK];
   assign w_win_up    = w_ev[c_BTN_UP] & ~w_ev[c_BTN_SHIFT] & ~w_ev[c_BTN_CHMOD] & ~w_ev[c_BTN_OK];
   assign w_win_down  = w_ev[c_BTN_DOWN] & ~(|w_ev[c_NUM_BTN-1:c_BTN_UP]);
   assign w_any_ev    = |w_ev;

   state_t     r_state;
   logic [2:0] r_cursor;
   logic [6:0] r_ring_cnt;
   logic [8:0] r_snooze_cnt;
   logic       r_am_d, r_alarm_on, r_ring_en;
   logic       r_inc, r_dec, r_commit_now, r_commit_arm, r_cancel;
   logic       w_alarm_rise;

   assign w_alarm_rise = bus.alarm_match & ~r_am_d & r_alarm_on;

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         r_state      <= ST_WATCH;
         r_cursor     <= '0;
         r_ring_cnt   <= '0;
         r_snooze_cnt <= '0;
         r_am_d       <= 1'b0;
         r_alarm_on   <= 1'b0;
         r_ring_en    <= 1'b0;
         r_inc        <= 1'b0;
         r_dec        <= 1'b0;
         r_commit_now <= 1'b0;
         r_commit_arm <= 1'b0;
         r_cancel     <= 1'b0;
      end else begin
         r_am_d       <= bus.alarm_match;
         r_inc        <= 1'b0;
         r_dec        <= 1'b0;
         r_commit_now <= 1'b0;
         r_commit_arm <= 1'b0;
         r_cancel     <= 1'b0;
         case (r_state)
            ST_WATCH: begin
               if (w_alarm_rise) begin
                  r_state    <= ST_RING;
                  r_ring_en  <= 1'b1;
                  r_ring_cnt <= '0;
               end else if (w_win_chmod) begin
                  r_state  <= ST_SET_NOW;
                  r_cursor <= '0;
               end else if (w_win_shift) begin
                  r_alarm_on <= ~r_alarm_on;
               end
            end
            ST_SET_NOW, ST_SET_ARM: begin
               if (w_alarm_rise) begin
                  r_cancel   <= 1'b1;
                  r_state    <= ST_RING;
                  r_ring_en  <= 1'b1;
                  r_ring_cnt <= '0;
               end else if (w_win_ok) begin
                  r_state <= ST_WATCH;
                  if (r_state == ST_SET_NOW) begin
                     r_commit_now <= 1'b1;
                  end else begin
                     r_commit_arm <= 1'b1;
                     r_alarm_on   <= 1'b1;
                  end
               end else if (w_win_chmod) begin
                  r_cancel <= 1'b1;
                  if (r_state == ST_SET_NOW) begin
                     r_state  <= ST_SET_ARM;
                     r_cursor <= '0;
                  end else begin
                     r_state <= ST_WATCH;
                  end
               end else if (w_win_shift) begin
                  r_cursor <= (r_cursor == c_CURSOR_LAST) ? 3'd0 : r_cursor + 3'd1;
               end else if (w_win_up) begin
                  r_inc <= 1'b1;
               end else if (w_win_down) begin
                  r_dec <= 1'b1;
               end
            end
            ST_RING: begin
               if (w_any_ev) begin
                  r_ring_en <= 1'b0;
`ifdef MODE_SEQ_SNOOZE_EN
                  if (w_win_up | w_win_down) begin
                     r_state      <= ST_SNOOZE;
                     r_snooze_cnt <= '0;
                  end else begin
                     r_state <= ST_WATCH;
                  end
`else
                  r_state <= ST_WATCH;
`endif
               end else if (bus.sec_tick) begin
                  r_ring_cnt <= r_ring_cnt + 7'd1;
                  if (r_ring_cnt == c_RING_LAST) begin
                     r_state   <= ST_WATCH;
                     r_ring_en <= 1'b0;
                  end
               end
            end
            // Only entered from RING when the snooze build is selected.
            ST_SNOOZE: begin
               if (w_win_ok) begin
                  r_state <= ST_WATCH;
               end else if (bus.sec_tick) begin
                  r_snooze_cnt <= r_snooze_cnt + 9'd1;
                  if (r_snooze_cnt == c_SNOOZE_LAST) begin
                     r_state    <= ST_RING;
                     r_ring_en  <= 1'b1;
                     r_ring_cnt <= '0;
                  end
               end
            end
            default: begin
               r_state   <= ST_WATCH;
               r_ring_en <= 1'b0;
            end
         endcase
      end
   end

   assign bus.STATE      = r_state;
   assign bus.cursor     = r_cursor;
   assign bus.inc_pulse  = r_inc;
   assign bus.dec_pulse  = r_dec;
   assign bus.commit_now = r_commit_now;
   assign bus.commit_arm = r_commit_arm;
   assign bus.cancel     = r_cancel;
   assign bus.alarm_on   = r_alarm_on;
   assign bus.ring_en    = r_ring_en;
endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// =============================================================================
// tb_mode_sequencer : directed self-checking bench (DEBOUNCE_CYC=4, RING_SEC=3,
// SNOOZE_SEC=2). Rev 1.0
// =============================================================================
module tb_mode_sequencer;
   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   mode_sequencer_if bus ();

   mode_sequencer #(
      .DEBOUNCE_CYC(4),
      .RING_SEC    (3),
      .SNOOZE_SEC  (2),
      .NUM_FIELDS  (6)
   ) dut (
      .CLK   (clk),
      .RESETN(resetn),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse and transition tallies, sampled 2 ns after each rising edge.
   int         n_inc, n_dec, n_cnow, n_carm, n_cancel, n_trans;
   logic [2:0] prev_state;
   initial begin
      n_inc = 0; n_dec = 0; n_cnow = 0; n_carm = 0; n_cancel = 0; n_trans = 0;
      prev_state = 3'd0;
   end
   always @(posedge clk) begin
      #2;
      if (bus.inc_pulse === 1'b1)  n_inc++;
      if (bus.dec_pulse === 1'b1)  n_dec++;
      if (bus.commit_now === 1'b1) n_cnow++;
      if (bus.commit_arm === 1'b1) n_carm++;
      if (bus.cancel === 1'b1)     n_cancel++;
      if (bus.STATE !== prev_state) n_trans++;
      prev_state = bus.STATE;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: bus.down  = v;
         1: bus.up    = v;
         2: bus.shift = v;
         3: bus.chmod = v;
         default: bus.OK = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      cyc(8);
      set_btn(b, 1'b0);
      cyc(12);
   endtask

   task automatic tick();
      bus.sec_tick = 1'b1;
      cyc(1);
      bus.sec_tick = 1'b0;
      cyc(1);
   endtask

   int b_inc, b_dec, b_cnow, b_carm, b_cancel, b_trans;
   task automatic snap();
      b_inc = n_inc; b_dec = n_dec; b_cnow = n_cnow;
      b_carm = n_carm; b_cancel = n_cancel; b_trans = n_trans;
   endtask

   initial begin
      checks = 0; failures = 0;
      resetn = 1'b0;
      bus.chmod = 1'b0; bus.OK = 1'b0; bus.shift = 1'b0; bus.up = 1'b0;
      bus.down = 1'b0; bus.sec_tick = 1'b0; bus.alarm_match = 1'b0;
      cyc(3);
      chk("rst_state", 32'(bus.STATE), 0);
      chk("rst_cursor", 32'(bus.cursor), 0);
      chk("rst_alarm_on", 32'(bus.alarm_on), 0);
      chk("rst_ring_en", 32'(bus.ring_en), 0);
      chk("rst_pulses", 32'({bus.inc_pulse, bus.dec_pulse, bus.commit_now,
                             bus.commit_arm, bus.cancel}), 0);
      resetn = 1'b1;
      cyc(2);

      // 1: chmod held 10 cycles; mode changes exactly at cycle 8 after the rise
      snap();
      bus.chmod = 1'b1;
      cyc(7);
      chk("t1_state_c7", 32'(bus.STATE), 0);
      cyc(1);
      chk("t1_state_c8", 32'(bus.STATE), 1);
      chk("t1_cursor", 32'(bus.cursor), 0);
      cyc(2);
      bus.chmod = 1'b0;
      cyc(12);
      chk("t1_state_after", 32'(bus.STATE), 1);
      chk("t1_one_trans", 32'(n_trans - b_trans), 1);

      // 2: cursor walk with wrap, increment, commit
      press(2); chk("t2_cur1", 32'(bus.cursor), 1);
      press(2); chk("t2_cur2", 32'(bus.cursor), 2);
      press(2); chk("t2_cur3", 32'(bus.cursor), 3);
      press(2); chk("t2_cur4", 32'(bus.cursor), 4);
      press(2); chk("t2_cur5", 32'(bus.cursor), 5);
      press(2); chk("t2_cur0", 32'(bus.cursor), 0);
      press(2); chk("t2_cur1b", 32'(bus.cursor), 1);
      snap();
      press(1);
      chk("t2_inc_one", 32'(n_inc - b_inc), 1);
      chk("t2_state_set", 32'(bus.STATE), 1);
      snap();
      press(4);
      chk("t2_commit_now", 32'(n_cnow - b_cnow), 1);
      chk("t2_state_watch", 32'(bus.STATE), 0);
      chk("t2_cursor_hold", 32'(bus.cursor), 1);

      // 3: alarm set, ring, auto-stop after 3 seconds
      press(3);
      snap();
      press(3);
      chk("t3_state_arm", 32'(bus.STATE), 2);
      chk("t3_cursor0", 32'(bus.cursor), 0);
      chk("t3_cancel", 32'(n_cancel - b_cancel), 1);
      snap();
      press(4);
      chk("t3_commit_arm", 32'(n_carm - b_carm), 1);
      chk("t3_alarm_on", 32'(bus.alarm_on), 1);
      chk("t3_state_watch", 32'(bus.STATE), 0);
      bus.alarm_match = 1'b1;
      cyc(1);
      chk("t3_state_ring", 32'(bus.STATE), 3);
      chk("t3_ring_en", 32'(bus.ring_en), 1);
      tick(); tick();
      chk("t3_still_ring", 32'(bus.STATE), 3);
      tick();
      chk("t3_ring_stop", 32'(bus.STATE), 0);
      chk("t3_ring_off", 32'(bus.ring_en), 0);
      bus.alarm_match = 1'b0;
      cyc(2);

      // 4: OK beats up; short glitch is rejected
      press(3);
      chk("t4_set_now", 32'(bus.STATE), 1);
      snap();
      bus.OK = 1'b1; bus.up = 1'b1;
      cyc(8);
      bus.OK = 1'b0; bus.up = 1'b0;
      cyc(12);
      chk("t4_commit_now", 32'(n_cnow - b_cnow), 1);
      chk("t4_no_inc", 32'(n_inc - b_inc), 0);
      chk("t4_state_watch", 32'(bus.STATE), 0);
      press(3);
      snap();
      bus.down = 1'b1;
      cyc(2);
      bus.down = 1'b0;
      cyc(12);
      chk("t4_glitch_no_dec", 32'(n_dec - b_dec), 0);
      press(0);
      chk("t4_dec_one", 32'(n_dec - b_dec), 1);

      // 5: alarm pre-empts edit; reset mid-ring
      snap();
      bus.alarm_match = 1'b1;
      cyc(2);
      chk("t5_cancel", 32'(n_cancel - b_cancel), 1);
      chk("t5_state_ring", 32'(bus.STATE), 3);
      chk("t5_ring_en", 32'(bus.ring_en), 1);
      resetn = 1'b0;
      cyc(1);
      resetn = 1'b1;
      chk("t5_rst_state", 32'(bus.STATE), 0);
      chk("t5_rst_alarm_on", 32'(bus.alarm_on), 0);
      chk("t5_rst_ring_en", 32'(bus.ring_en), 0);
      cyc(3);
      chk("t5_no_ring_disarmed", 32'(bus.STATE), 0);
      bus.alarm_match = 1'b0;
      cyc(2);

      // 6: button during ring
      press(2);
      chk("t6_alarm_on", 32'(bus.alarm_on), 1);
      bus.alarm_match = 1'b1;
      cyc(2);
      chk("t6_state_ring", 32'(bus.STATE), 3);
      press(1);
`ifdef MODE_SEQ_SNOOZE_EN
      chk("t6_snooze", 32'(bus.STATE), 4);
      chk("t6_snooze_ring_off", 32'(bus.ring_en), 0);
      tick();
      chk("t6_snooze_hold", 32'(bus.STATE), 4);
      tick();
      chk("t6_rering", 32'(bus.STATE), 3);
      chk("t6_rering_en", 32'(bus.ring_en), 1);
      press(4);
      chk("t6_ok_watch", 32'(bus.STATE), 0);
`else
      chk("t6_stop_watch", 32'(bus.STATE), 0);
      chk("t6_stop_ring_off", 32'(bus.ring_en), 0);
`endif
      bus.alarm_match = 1'b0;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
